// File: rtl/nanov_serial_alu_pkg.sv
// Shared definitions for the nanoV bit-serial ALU: op codes, FSM encoding, defaults.
// NANOV_ALU_CMP_WB_EN adds the CMPWB state used by the SLT/SLTU rd writeback pass.
package nanov_serial_alu_pkg;

  localparam int XLEN_DFLT     = 32;
  localparam int CNT_BITS_DFLT = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_EQ   = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
`ifdef NANOV_ALU_CMP_WB_EN
    ST_CMPWB = 2'd2,
`endif
    ST_DONE  = 2'd3
  } alu_state_t;

  // Ops that run the adder as a + ~b + 1.
  function automatic logic op_subtracts(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_EQ) || (op == OP_SLT) || (op == OP_SLTU);
  endfunction

  // Compare-class ops update cmp_out and never write rd during RUN.
  function automatic logic op_is_cmp(input logic [3:0] op);
    return (op == OP_EQ) || (op == OP_SLT) || (op == OP_SLTU);
  endfunction

endpackage

// File: rtl/nanov_serial_alu_if.sv
// Control and bit-stream bundle between the register file / decoder and the serial ALU.
// Handshake: start is taken only while busy is low; rd_bit is meaningful only when rd_wr is high.
interface nanov_serial_alu_if
  import nanov_serial_alu_pkg::*;
#(
  parameter int CNT_BITS = 5
);
  logic                start;
  logic                flush;
  logic [3:0]          op;
  logic                a_bit;
  logic                b_bit;
  logic                rd_bit;
  logic                rd_wr;
  logic                busy;
  logic                done;
  logic                cmp_out;
  logic [CNT_BITS-1:0] bit_idx;
  alu_state_t          dbg_state;

  modport master (
    output start, flush, op, a_bit, b_bit,
    input  rd_bit, rd_wr, busy, done, cmp_out, bit_idx, dbg_state
  );

  modport slave (
    input  start, flush, op, a_bit, b_bit,
    output rd_bit, rd_wr, busy, done, cmp_out, bit_idx, dbg_state
  );
endinterface

// File: rtl/nanov_serial_alu_adder.sv
// One-bit full adder with a carry flop; optionally inverts b for subtract-style ops.
module nanov_serial_alu_adder (
  input  logic clk,
  input  logic rstn,
  input  logic a,
  input  logic b,
  input  logic inv_b,
  input  logic load,
  input  logic carry_init,
  input  logic en,
  output logic sum,
  output logic carry_out
);
  logic carry_q;
  logic b_eff;

  assign b_eff     = b ^ inv_b;
  assign sum       = a ^ b_eff ^ carry_q;
  assign carry_out = (a & b_eff) | (carry_q & (a ^ b_eff));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      carry_q <= 1'b0;
    end else if (load) begin
      carry_q <= carry_init;
    end else if (en) begin
      carry_q <= carry_out;
    end
  end
endmodule

// File: rtl/nanov_serial_alu.sv
// Bit-serial LSB-first ALU for nanoV: result stream to rd plus a registered branch compare flag.
// NANOV_ALU_CMP_WB_EN enables the extra XLEN-cycle pass that writes the SLT/SLTU result to rd.
module nanov_serial_alu
  import nanov_serial_alu_pkg::*;
#(
  parameter int XLEN     = XLEN_DFLT,
  parameter int CNT_BITS = CNT_BITS_DFLT
) (
  input  logic              clk,
  input  logic              rstn,
  nanov_serial_alu_if.slave alu
);
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(XLEN - 1);

  alu_state_t          state;
  logic [3:0]          op_q;
  logic [CNT_BITS-1:0] cnt;
  logic                ne_q;
  logic                cmp_q;

  logic sum;
  logic cout;
  logic add_load;
  logic run_res;
  logic run_wr;
  logic ne_now;
  logic cmp_now;
  logic wr_c;
  logic bit_c;

  assign add_load = (state == ST_IDLE) && alu.start && !alu.flush;

  nanov_serial_alu_adder u_adder (
    .clk        (clk),
    .rstn       (rstn),
    .a          (alu.a_bit),
    .b          (alu.b_bit),
    .inv_b      (op_subtracts(op_q)),
    .load       (add_load),
    .carry_init (op_subtracts(alu.op)),
    .en         (state == ST_RUN),
    .sum        (sum),
    .carry_out  (cout)
  );

  always_comb begin
    run_res = sum;
    case (op_q)
      OP_AND:  run_res = alu.a_bit & alu.b_bit;
      OP_OR:   run_res = alu.a_bit | alu.b_bit;
      OP_XOR:  run_res = alu.a_bit ^ alu.b_bit;
      default: run_res = sum;
    endcase
    run_wr = !op_is_cmp(op_q);
  end

  // Only meaningful on the MSB cycle; the sign rule handles SLT overflow.
  always_comb begin
    ne_now  = ne_q | (alu.a_bit ^ alu.b_bit);
    cmp_now = cmp_q;
    case (op_q)
      OP_EQ:   cmp_now = !ne_now;
      OP_SLT:  cmp_now = (alu.a_bit ^ alu.b_bit) ? alu.a_bit : sum;
      OP_SLTU: cmp_now = !cout;
      default: cmp_now = cmp_q;
    endcase
  end

  always_comb begin
    wr_c  = 1'b0;
    bit_c = 1'b0;
    if (!alu.flush) begin
      case (state)
        ST_RUN: begin
          wr_c  = run_wr;
          bit_c = run_wr & run_res;
        end
`ifdef NANOV_ALU_CMP_WB_EN
        ST_CMPWB: begin
          wr_c  = 1'b1;
          bit_c = (cnt == '0) ? cmp_q : 1'b0;
        end
`endif
        default: begin
          wr_c  = 1'b0;
          bit_c = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      op_q  <= OP_ADD;
      cnt   <= '0;
      ne_q  <= 1'b0;
      cmp_q <= 1'b0;
    end else if (alu.flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (alu.start) begin
            state <= ST_RUN;
            op_q  <= alu.op;
            cnt   <= '0;
            ne_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Counter wraps to 0 on the last bit so CMPWB starts at bit 0 with no bubble.
          cnt  <= cnt + CNT_BITS'(1);
          ne_q <= ne_now;
          if (cnt == LAST) begin
            if (op_is_cmp(op_q)) begin
              cmp_q <= cmp_now;
            end
`ifdef NANOV_ALU_CMP_WB_EN
            if ((op_q == OP_SLT) || (op_q == OP_SLTU)) begin
              state <= ST_CMPWB;
            end else begin
              state <= ST_DONE;
            end
`else
            state <= ST_DONE;
`endif
          end
        end
`ifdef NANOV_ALU_CMP_WB_EN
        ST_CMPWB: begin
          cnt <= cnt + CNT_BITS'(1);
          if (cnt == LAST) begin
            state <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu.rd_wr     = wr_c;
  assign alu.rd_bit    = bit_c;
  assign alu.busy      = (state != ST_IDLE);
  assign alu.done      = (state == ST_DONE);
  assign alu.cmp_out   = cmp_q;
  assign alu.bit_idx   = cnt;
  assign alu.dbg_state = state;

endmodule

// File: tb/tb_nanov_serial_alu.sv
// Directed plus random bench for nanov_serial_alu: rd words scoreboarded, compare flag and latency checked.
module tb_nanov_serial_alu;
  import nanov_serial_alu_pkg::*;

`ifdef NANOV_ALU_CMP_WB_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic clk;
  logic rstn;

  nanov_serial_alu_if #(.CNT_BITS(5)) ifc ();

  nanov_serial_alu #(.XLEN(32), .CNT_BITS(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .alu  (ifc)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] rd_acc;
  bit          wr_seen  = 0;
  bit          last_wr  = 0;
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  logic        exp_cmp  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifc.start && !ifc.busy) wr_seen = 0;
    if (ifc.rd_wr) begin
      rd_acc[ifc.bit_idx] = ifc.rd_bit;
      wr_seen = 1;
    end
    if (ifc.done) begin
      done_cnt++;
      done_cyc = cyc;
      last_wr  = wr_seen;
      if (wr_seen) begin
        chk("rd_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("rd_word", rd_acc, exp_q.pop_front());
      end
      wr_seen = 0;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_rd(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'd0, a < b};
      default: return a + b;
    endcase
  endfunction

  function automatic logic model_cmp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      OP_EQ:   return a == b;
      OP_SLT:  return $signed(a) < $signed(b);
      default: return a < b;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_start(input logic [3:0] o, output int unsigned t0);
    @(posedge clk); #1;
    t0 = cyc;
    ifc.start = 1'b1;
    ifc.op    = o;
    @(posedge clk); #1;
    ifc.start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int unsigned t0;
    int unsigned dc0;
    int          n;
    bit          is_cmp;
    bit          writes;
    int unsigned lat;
    is_cmp = (o == OP_EQ) || (o == OP_SLT) || (o == OP_SLTU);
    writes = !is_cmp || (WB && (o != OP_EQ));
    lat    = (WB && ((o == OP_SLT) || (o == OP_SLTU))) ? 65 : 33;
    if (writes) exp_q.push_back(model_rd(o, a, b));
    if (is_cmp) exp_cmp = model_cmp(o, a, b);
    dc0 = done_cnt;
    drive_start(o, t0);
    chk({tag, "_busy"}, 32'(ifc.busy), 32'd1);
    for (int k = 0; k < 32; k++) begin
      ifc.a_bit = a[k];
      ifc.b_bit = b[k];
      @(posedge clk); #1;
    end
    n = 0;
    while ((done_cnt == dc0) && (n < 100)) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt - dc0), 32'd1);
    chk({tag, "_latency"}, done_cyc - t0, lat);
    chk({tag, "_wrote"}, 32'(last_wr), 32'(writes));
    if (is_cmp) chk({tag, "_cmp"}, 32'(ifc.cmp_out), 32'(exp_cmp));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int unsigned t0;
    int unsigned dc0;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  ro;

    rstn = 1'b0;
    ifc.start = 1'b0; ifc.flush = 1'b0; ifc.op = OP_ADD; ifc.a_bit = 1'b0; ifc.b_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(ifc.busy),      32'd0);
    chk("rst_done",   32'(ifc.done),      32'd0);
    chk("rst_rd_wr",  32'(ifc.rd_wr),     32'd0);
    chk("rst_rd_bit", 32'(ifc.rd_bit),    32'd0);
    chk("rst_cmp",    32'(ifc.cmp_out),   32'd0);
    chk("rst_idx",    32'(ifc.bit_idx),   32'd0);
    chk("rst_state",  32'(ifc.dbg_state), 32'(ST_IDLE));
    rstn = 1'b1;

    run_op("add_5_3",   OP_ADD,  32'h0000_0005, 32'h0000_0003);
    run_op("sub_0_1",   OP_SUB,  32'h0000_0000, 32'h0000_0001);
    run_op("sltu_0_1",  OP_SLTU, 32'h0000_0000, 32'h0000_0001);
    run_op("slt_m1_1",  OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001);
    run_op("sltu_m1_1", OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("and",       OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF);
    run_op("or",        OP_OR,   32'hA000_0001, 32'h0500_8000);
    run_op("xor",       OP_XOR,  32'hDEAD_BEEF, 32'hFFFF_0000);
    run_op("undef_add", 4'hF,    32'h7FFF_FFFF, 32'h0000_0001);
    run_op("eq_flip",   OP_EQ,   32'hDEAD_BEEF, 32'h5EAD_BEEF);
    run_op("eq_same",   OP_EQ,   32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // flush at bit 10 of an ADD with a simultaneous start
    dc0 = done_cnt;
    drive_start(OP_ADD, t0);
    for (int k = 0; k < 10; k++) begin
      ifc.a_bit = 1'b1;
      ifc.b_bit = 1'b0;
      @(posedge clk); #1;
    end
    chk("flush_idx", 32'(ifc.bit_idx), 32'd10);
    ifc.flush = 1'b1;
    ifc.start = 1'b1;
    @(negedge clk);
    chk("flush_rd_wr", 32'(ifc.rd_wr), 32'd0);
    @(posedge clk); #1;
    ifc.flush = 1'b0;
    ifc.start = 1'b0;
    @(negedge clk);
    chk("flush_busy",  32'(ifc.busy),      32'd0);
    chk("flush_state", 32'(ifc.dbg_state), 32'(ST_IDLE));
    // start together with flush while idle must not launch an op
    @(posedge clk); #1;
    ifc.flush = 1'b1;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.flush = 1'b0;
    ifc.start = 1'b0;
    chk("flush_idle_start", 32'(ifc.busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_no_done", done_cnt - dc0, 32'd0);
    chk("flush_cmp_hold", 32'(ifc.cmp_out), 32'(exp_cmp));

    for (int i = 0; i < 6; i++) begin
      ro = 4'($urandom_range(0, 4));
      ra = $urandom;
      rb = $urandom;
      run_op("rand", ro, ra, rb);
    end

    // async reset at bit 20; cmp_out is set beforehand so clearing is visible
    run_op("slt_pre_rst", OP_SLT, 32'h8000_0000, 32'h0000_0000);
    drive_start(OP_ADD, t0);
    for (int k = 0; k < 20; k++) begin
      ifc.a_bit = 1'b1;
      ifc.b_bit = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid_idx", 32'(ifc.bit_idx), 32'd20);
    rstn = 1'b0;
    exp_cmp = 1'b0;
    #1;
    chk("arst_busy",   32'(ifc.busy),    32'd0);
    chk("arst_rd_wr",  32'(ifc.rd_wr),   32'd0);
    chk("arst_rd_bit", 32'(ifc.rd_bit),  32'd0);
    chk("arst_done",   32'(ifc.done),    32'd0);
    chk("arst_cmp",    32'(ifc.cmp_out), 32'd0);
    chk("arst_idx",    32'(ifc.bit_idx), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    run_op("add_1_1", OP_ADD, 32'h0000_0001, 32'h0000_0001);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
